// File: rtl/dual_pkg.sv
// Shared types and sizing for the dual-issue writeback path.
// Holds register-file geometry, pending-write FIFO sizing and the entry struct.
// Also provides the forwarding lookup used by the writeback arbiter.
package dual_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int DATA_W          = 32;
  localparam int WB_FIFO_DEPTH   = 4;
  localparam int WB_STALL_THRESH = 3;

  // Pointer and count widths derived from the FIFO depth.
  localparam int PTR_W = $clog2(WB_FIFO_DEPTH);
  localparam int CNT_W = $clog2(WB_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // Youngest-match search over pending writes. FIFO entries arrive ordered
  // oldest first, then lane-1, then lane-2, so a later match overrides an
  // earlier one. Register 0 never hits. Result is {hit, data}.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [REG_ADDR_W-1:0]               addr,
    input wb_entry_t [WB_FIFO_DEPTH-1:0]       ent,
    input logic [WB_FIFO_DEPTH-1:0]            ent_vld,
    input logic                                lane1_vld,
    input wb_entry_t                           lane1,
    input logic                                lane2_vld,
    input wb_entry_t                           lane2
  );
    logic              hit;
    logic [DATA_W-1:0] data;
    hit  = 1'b0;
    data = '0;
    if (addr != '0) begin
      for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
        if (ent_vld[i] && (ent[i].addr == addr)) begin
          hit  = 1'b1;
          data = ent[i].data;
        end
      end
      if (lane1_vld && (lane1.addr == addr)) begin
        hit  = 1'b1;
        data = lane1.data;
      end
      if (lane2_vld && (lane2.addr == addr)) begin
        hit  = 1'b1;
        data = lane2.data;
      end
    end
    return {hit, data};
  endfunction

endpackage

// File: rtl/wb_pending_fifo.sv
// Pending-write queue: two pushes and one pop per cycle, entries exposed oldest-first.
// Latency: a pushed entry is visible at the head / in the age view the cycle after the push.
// No internal backpressure; the owner bounds occupancy and only pops when non-empty.
module wb_pending_fifo
  import dual_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push_a_vld,
  input  wb_entry_t                         push_a_dat,
  input  logic                              push_b_vld,
  input  wb_entry_t                         push_b_dat,
  input  logic                              pop,
  output wb_entry_t                         head_dat,
  output logic [CNT_W-1:0]                  count,
  output wb_entry_t [WB_FIFO_DEPTH-1:0]     age_dat,
  output logic [WB_FIFO_DEPTH-1:0]          age_vld
);

  wb_entry_t          mem [WB_FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   n_push;

  // push_b is only ever used together with push_a, so it lands one slot later.
  assign n_push = CNT_W'(push_a_vld) + CNT_W'(push_b_vld);

  // Pointer and occupancy update; pointers wrap naturally at the depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + n_push - CNT_W'(pop);
    end
  end

  // Entry storage; contents beyond the occupancy are don't-care.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push_a_vld) begin
        mem[wr_ptr] <= push_a_dat;
      end
      if (push_b_vld) begin
        mem[wr_ptr + PTR_W'(1)] <= push_b_dat;
      end
    end
  end

  assign head_dat = mem[rd_ptr];

  // Age-ordered view for forwarding: slot 0 is the head (oldest).
  always_comb begin
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      age_dat[i] = mem[rd_ptr + PTR_W'(i)];
      age_vld[i] = (CNT_W'(i) < count);
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges two writeback lanes onto a single register-file write port in program order.
// Latency: zero when nothing is queued; otherwise writes drain one per cycle from the queue.
// Raises wb_stall at three queued writes; lane inputs are ignored while stalled or in reset.
module wb_write_arbiter
  import dual_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWriteEn_inst1_WB,
  input  logic [REG_ADDR_W-1:0] dest_reg_inst1_WB,
  input  logic [DATA_W-1:0]     writeData_inst1_WB,
  input  logic                  RegWriteEn_inst2_WB,
  input  logic [REG_ADDR_W-1:0] dest_reg_inst2_WB,
  input  logic [DATA_W-1:0]     writeData_inst2_WB,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  wb_stall,
  input  logic [REG_ADDR_W-1:0] fwd_addr_a,
  input  logic [REG_ADDR_W-1:0] fwd_addr_b,
  output logic                  fwd_hit_a,
  output logic [DATA_W-1:0]     fwd_data_a,
  output logic                  fwd_hit_b,
  output logic [DATA_W-1:0]     fwd_data_b
);

  wb_entry_t                     lane1;
  wb_entry_t                     lane2;
  logic                          sample;
  logic                          lane1_acc;
  logic                          lane2_acc;
  logic                          stall_raw;

  logic                          push_a_vld;
  logic                          push_b_vld;
  wb_entry_t                     push_a_dat;
  wb_entry_t                     push_b_dat;
  logic                          pop;
  wb_entry_t                     head_dat;
  logic [CNT_W-1:0]              count;
  wb_entry_t [WB_FIFO_DEPTH-1:0] age_dat;
  logic [WB_FIFO_DEPTH-1:0]      age_vld;
  logic [WB_FIFO_DEPTH-1:0]      fwd_vld;
  logic [DATA_W:0]               fwd_res_a;
  logic [DATA_W:0]               fwd_res_b;

  assign lane1 = '{addr: dest_reg_inst1_WB, data: writeData_inst1_WB};
  assign lane2 = '{addr: dest_reg_inst2_WB, data: writeData_inst2_WB};

  // Stall comes straight from the registered occupancy, masked during reset.
  assign stall_raw = (count >= CNT_W'(WB_STALL_THRESH));
  assign wb_stall  = stall_raw && !reset;
  assign sample    = !reset && !stall_raw;

  // Writes to x0 are dropped; lane-1 is shadowed by a same-register lane-2 write.
  assign lane2_acc = sample && RegWriteEn_inst2_WB && (dest_reg_inst2_WB != '0);
  assign lane1_acc = sample && RegWriteEn_inst1_WB && (dest_reg_inst1_WB != '0)
                     && !(RegWriteEn_inst2_WB && (dest_reg_inst2_WB == dest_reg_inst1_WB));

  // Write-port selection and enqueue: queue head first, else lanes bypass the queue.
  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    pop        = 1'b0;
    push_a_vld = 1'b0;
    push_b_vld = 1'b0;
    push_a_dat = lane1;
    push_b_dat = lane2;
    if (!reset) begin
      if (count != '0) begin
        pop      = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = head_dat.addr;
        rf_wdata = head_dat.data;
        // Both accepted lanes queue behind the head; compact so push_a is the older.
        if (lane1_acc) begin
          push_a_vld = 1'b1;
          push_b_vld = lane2_acc;
        end else if (lane2_acc) begin
          push_a_vld = 1'b1;
          push_a_dat = lane2;
        end
      end else if (lane1_acc) begin
        rf_we      = 1'b1;
        rf_waddr   = lane1.addr;
        rf_wdata   = lane1.data;
        push_a_vld = lane2_acc;
        push_a_dat = lane2;
      end else if (lane2_acc) begin
        rf_we    = 1'b1;
        rf_waddr = lane2.addr;
        rf_wdata = lane2.data;
      end
    end
  end

  wb_pending_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_a_vld (push_a_vld),
    .push_a_dat (push_a_dat),
    .push_b_vld (push_b_vld),
    .push_b_dat (push_b_dat),
    .pop        (pop),
    .head_dat   (head_dat),
    .count      (count),
    .age_dat    (age_dat),
    .age_vld    (age_vld)
  );

  // Queued entries are still architecturally lost on reset, so hide them that cycle.
  assign fwd_vld = age_vld & {WB_FIFO_DEPTH{!reset}};

  // Forwarding covers the head even while it retires: the regfile updates next cycle.
  assign fwd_res_a = fwd_lookup(fwd_addr_a, age_dat, fwd_vld, lane1_acc, lane1, lane2_acc, lane2);
  assign fwd_res_b = fwd_lookup(fwd_addr_b, age_dat, fwd_vld, lane1_acc, lane1, lane2_acc, lane2);

  assign fwd_hit_a  = fwd_res_a[DATA_W];
  assign fwd_data_a = fwd_res_a[DATA_W-1:0];
  assign fwd_hit_b  = fwd_res_b[DATA_W];
  assign fwd_data_b = fwd_res_b[DATA_W-1:0];

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for the writeback arbiter: per-cycle vector table plus a
// continuous dual-issue sequence with upstream hold on stall.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_wb_write_arbiter;
  import dual_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  en1 = 1'b0;
  logic [REG_ADDR_W-1:0] d1 = '0;
  logic [DATA_W-1:0]     w1 = '0;
  logic                  en2 = 1'b0;
  logic [REG_ADDR_W-1:0] d2 = '0;
  logic [DATA_W-1:0]     w2 = '0;
  logic [REG_ADDR_W-1:0] fa = '0;
  logic [REG_ADDR_W-1:0] fb = '0;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  wb_stall;
  logic                  hit_a;
  logic                  hit_b;
  logic [DATA_W-1:0]     data_a;
  logic [DATA_W-1:0]     data_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_write_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .RegWriteEn_inst1_WB (en1),
    .dest_reg_inst1_WB   (d1),
    .writeData_inst1_WB  (w1),
    .RegWriteEn_inst2_WB (en2),
    .dest_reg_inst2_WB   (d2),
    .writeData_inst2_WB  (w2),
    .rf_we               (rf_we),
    .rf_waddr            (rf_waddr),
    .rf_wdata            (rf_wdata),
    .wb_stall            (wb_stall),
    .fwd_addr_a          (fa),
    .fwd_addr_b          (fb),
    .fwd_hit_a           (hit_a),
    .fwd_data_a          (data_a),
    .fwd_hit_b           (hit_b),
    .fwd_data_b          (data_b)
  );

  typedef struct {
    int rst; int e1; int d1; int w1; int e2; int d2; int w2; int fa; int fb;
    int we;  int wa; int wd; int st; int cnt; int ha; int da; int hb; int db;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rst, int e1, int d1, int w1, int e2, int d2, int w2,
                              int fa, int fb, int we, int wa, int wd, int st, int cnt,
                              int ha, int da, int hb, int db);
    vec_t v;
    v.rst = rst; v.e1 = e1; v.d1 = d1; v.w1 = w1; v.e2 = e2; v.d2 = d2; v.w2 = w2;
    v.fa = fa; v.fb = fb; v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.cnt = cnt;
    v.ha = ha; v.da = da; v.hb = hb; v.db = db;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input int rst, input int e1, input int dd1, input int ww1,
                       input int e2, input int dd2, input int ww2, input int a, input int b);
    reset = (rst != 0);
    en1 = (e1 != 0); d1 = REG_ADDR_W'(dd1); w1 = DATA_W'(ww1);
    en2 = (e2 != 0); d2 = REG_ADDR_W'(dd2); w2 = DATA_W'(ww2);
    fa = REG_ADDR_W'(a); fb = REG_ADDR_W'(b);
  endtask

  initial begin
    int exp_a[$];
    int exp_d[$];
    int idx;
    int nrx;
    int cyc;
    bit saw_stall;

    //          rst e1 d1  w1      e2 d2  w2      fa  fb | we wa  wd      st cnt ha da      hb db
    tbl.push_back(mk(1, 1, 5, 'h99,   0, 0, 0,      5,  0,   0, 0,  0,      0, 0,  0, 0,      0, 0));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0,  0,   0, 0,  0,      0, 0,  0, 0,      0, 0));
    // single lane-1 write bypasses the queue
    tbl.push_back(mk(0, 1, 5, 'h11,   0, 0, 0,      5,  0,   1, 5,  'h11,   0, 0,  1, 'h11,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      5,  0,   0, 0,  0,      0, 0,  0, 0,      0, 0));
    // dual write, distinct regs: x3 now, x4 next cycle from the queue
    tbl.push_back(mk(0, 1, 3, 'hA,    1, 4, 'hB,    4,  3,   1, 3,  'hA,    0, 0,  1, 'hB,    1, 'hA));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      4,  3,   1, 4,  'hB,    0, 1,  1, 'hB,    0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      4,  3,   0, 0,  0,      0, 0,  0, 0,      0, 0));
    // same destination on both lanes: only lane-2 survives
    tbl.push_back(mk(0, 1, 7, 1,      1, 7, 2,      7,  7,   1, 7,  2,      0, 0,  1, 2,      1, 2));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      7,  0,   0, 0,  0,      0, 0,  0, 0,      0, 0));
    // three back-to-back dual writes fill the queue to the stall threshold
    tbl.push_back(mk(0, 1, 1, 'h101,  1, 2, 'h102,  2,  0,   1, 1,  'h101,  0, 0,  1, 'h102,  0, 0));
    tbl.push_back(mk(0, 1, 3, 'h103,  1, 4, 'h104,  3,  2,   1, 2,  'h102,  0, 1,  1, 'h103,  1, 'h102));
    tbl.push_back(mk(0, 1, 5, 'h105,  1, 6, 'h106,  6,  4,   1, 3,  'h103,  0, 2,  1, 'h106,  1, 'h104));
    tbl.push_back(mk(0, 1, 8, 'h1EE,  1, 9, 'h1FF,  9,  5,   1, 4,  'h104,  1, 3,  0, 0,      1, 'h105));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      8,  6,   1, 5,  'h105,  0, 2,  0, 0,      1, 'h106));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      9,  6,   1, 6,  'h106,  0, 1,  0, 0,      1, 'h106));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      9,  8,   0, 0,  0,      0, 0,  0, 0,      0, 0));
    // forwarding from a queued non-head entry, then lane-2 overriding it
    tbl.push_back(mk(0, 1, 12, 'h12,  1, 13, 'h13,  0,  0,   1, 12, 'h12,   0, 0,  0, 0,      0, 0));
    tbl.push_back(mk(0, 1, 14, 'h14,  1, 9, 'hCC,   13, 0,   1, 13, 'h13,   0, 1,  1, 'h13,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      9,  0,   1, 14, 'h14,   0, 2,  1, 'hCC,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      1, 9, 'hDD,   9,  0,   1, 9,  'hCC,   0, 1,  1, 'hDD,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      9,  0,   1, 9,  'hDD,   0, 1,  1, 'hDD,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      9,  0,   0, 0,  0,      0, 0,  0, 0,      0, 0));
    // x0 requests are dropped
    tbl.push_back(mk(0, 1, 0, 'h55,   1, 0, 'h66,   0,  0,   0, 0,  0,      0, 0,  0, 0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      0,  0,   0, 0,  0,      0, 0,  0, 0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 5,      1, 15, 'hF,   15, 0,   1, 15, 'hF,    0, 0,  1, 'hF,    0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      0,  0,   0, 0,  0,      0, 0,  0, 0,      0, 0));
    // reset while three writes are queued
    tbl.push_back(mk(0, 1, 1, 1,      1, 2, 2,      0,  0,   1, 1,  1,      0, 0,  0, 0,      0, 0));
    tbl.push_back(mk(0, 1, 3, 3,      1, 4, 4,      0,  0,   1, 2,  2,      0, 1,  0, 0,      0, 0));
    tbl.push_back(mk(0, 1, 5, 5,      1, 6, 6,      0,  0,   1, 3,  3,      0, 2,  0, 0,      0, 0));
    tbl.push_back(mk(1, 1, 7, 7,      1, 8, 8,      5,  6,   0, 0,  0,      0, 3,  0, 0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      5,  6,   0, 0,  0,      0, 0,  0, 0,      0, 0));
    tbl.push_back(mk(0, 1, 20, 'h20,  0, 0, 0,      20, 0,   1, 20, 'h20,   0, 0,  1, 'h20,   0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].rst, tbl[i].e1, tbl[i].d1, tbl[i].w1, tbl[i].e2, tbl[i].d2, tbl[i].w2,
            tbl[i].fa, tbl[i].fb);
      @(negedge clk);
      chk("rf_we",      i, 32'(rf_we),          32'(tbl[i].we));
      chk("rf_waddr",   i, 32'(rf_waddr),       32'(tbl[i].wa));
      chk("rf_wdata",   i, rf_wdata,            32'(tbl[i].wd));
      chk("wb_stall",   i, 32'(wb_stall),       32'(tbl[i].st));
      chk("fifo_count", i, 32'(dut.u_fifo.count), 32'(tbl[i].cnt));
      chk("fwd_hit_a",  i, 32'(hit_a),          32'(tbl[i].ha));
      chk("fwd_data_a", i, data_a,              32'(tbl[i].da));
      chk("fwd_hit_b",  i, 32'(hit_b),          32'(tbl[i].hb));
      chk("fwd_data_b", i, data_b,              32'(tbl[i].db));
    end

    // Continuous dual issue with upstream holding while stalled: the write
    // port must carry every accepted write exactly once, in program order.
    for (int k = 0; k < 6; k++) begin
      exp_a.push_back(2 * k + 1); exp_d.push_back('hA000 + k);
      exp_a.push_back(2 * k + 2); exp_d.push_back('hB000 + k);
    end
    idx = 0;
    nrx = 0;
    cyc = 0;
    saw_stall = 1'b0;
    while ((idx < 6 || nrx < 12) && cyc < 80) begin
      @(posedge clk);
      #1;
      if (idx < 6)
        drive(0, 1, 2 * idx + 1, 'hA000 + idx, 1, 2 * idx + 2, 'hB000 + idx, 0, 0);
      else
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (wb_stall) saw_stall = 1'b1;
      if (rf_we) begin
        if (nrx < 12) begin
          chk("seq_waddr", nrx, 32'(rf_waddr), 32'(exp_a[nrx]));
          chk("seq_wdata", nrx, rf_wdata, 32'(exp_d[nrx]));
        end else begin
          chk("seq_extra_write", nrx, 32'(rf_we), 32'd0);
        end
        nrx++;
      end
      if (!wb_stall && idx < 6) idx++;
      cyc++;
    end
    chk("seq_retired", 0, 32'(nrx), 32'd12);
    chk("seq_saw_stall", 0, 32'(saw_stall), 32'd1);

    // Queue must be empty and idle once drained.
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("seq_idle_we", 0, 32'(rf_we), 32'd0);
    chk("seq_idle_stall", 0, 32'(wb_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
